// File: rtl/multi_ts_injection_manager_pkg.sv
// Shared types and defaults for the multi-flow TS injection manager.
// Holds the FSM encoding and the queue-full policy constants.
package multi_ts_injection_manager_pkg;

  localparam int FLOW_NUM_DEF = 32;
  localparam int FLOW_W_DEF   = 5;
  localparam int DESC_W_DEF   = 36;
  localparam int DEPTH_DEF    = 4;
  localparam int DEPTH_W_DEF  = 2;

  localparam logic OVR_DROP      = 1'b0;
  localparam logic OVR_OVERWRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_OUTPUT = 2'd2
  } tim_state_e;

endpackage

// File: rtl/multi_ts_injection_manager_flow_queue_ctrl.sv
// Pointer and occupancy control for one flow's circular descriptor queue.
// Storage lives in the top; this block only decides where and whether to write.
module ts_flow_queue_ctrl
  import multi_ts_injection_manager_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq,
  input  logic               deq,
  input  logic               ovw_mode,
  output logic               we,
  output logic               ovf,
  output logic               ovw,
  output logic [DEPTH_W-1:0] rd_ptr,
  output logic [DEPTH_W-1:0] wr_ptr,
  output logic [DEPTH_W:0]   count,
  output logic               nonempty_d
);

  localparam logic [DEPTH_W:0]   FULL_CNT = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W-1:0] LAST_PTR = DEPTH_W'(DEPTH - 1);

  logic [DEPTH_W-1:0] rd_q, rd_d;
  logic [DEPTH_W-1:0] wr_q, wr_d;
  logic [DEPTH_W:0]   cnt_q, cnt_d;
  logic               full;
  logic               do_deq;

  function automatic logic [DEPTH_W-1:0] ptr_inc(
    input logic [DEPTH_W-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full   = (cnt_q == FULL_CNT);
  assign do_deq = deq && (cnt_q != '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    ovf   = 1'b0;
    ovw   = 1'b0;
    if (enq && do_deq) begin
      // Simultaneous push/pop never overflows, even when full.
      we   = 1'b1;
      wr_d = ptr_inc(wr_q);
      rd_d = ptr_inc(rd_q);
    end else if (enq && !full) begin
      we    = 1'b1;
      wr_d  = ptr_inc(wr_q);
      cnt_d = cnt_q + 1'b1;
    end else if (enq && ovw_mode == OVR_OVERWRITE) begin
      we   = 1'b1;
      wr_d = ptr_inc(wr_q);
      rd_d = ptr_inc(rd_q);
      ovf  = 1'b1;
      ovw  = 1'b1;
    end else if (enq) begin
      ovf = 1'b1;
    end else if (do_deq) begin
      rd_d  = ptr_inc(rd_q);
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_ptr     = rd_q;
  assign wr_ptr     = wr_q;
  assign count      = cnt_q;
  assign nonempty_d = (cnt_d != '0);

endmodule

// File: rtl/multi_ts_injection_manager.sv
// Per-flow TS descriptor queues with a single request/ack injection port.
// Enqueues run every cycle; one injection is in flight at a time.
module multi_ts_injection_manager
  import multi_ts_injection_manager_pkg::*;
#(
  parameter int FLOW_NUM = FLOW_NUM_DEF,
  parameter int FLOW_W   = FLOW_W_DEF,
  parameter int DESC_W   = DESC_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DESC_W-1:0] iv_ts_descriptor,
  input  logic              i_ts_descriptor_wr,
  input  logic [FLOW_W-1:0] iv_ts_descriptor_waddr,
  input  logic              i_overwrite_mode,
  input  logic [FLOW_W-1:0] iv_ts_injection_addr,
  input  logic              i_ts_injection_addr_wr,
  output logic              o_ts_injection_addr_ack,
  output logic [DESC_W-1:0] ov_ts_descriptor,
  output logic              o_ts_descriptor_wr,
  input  logic              i_ts_descriptor_ack,
  output logic [FLOW_NUM-1:0] ov_ts_cnt,
  output logic              o_ts_overflow_error_pulse,
  output logic              o_ts_underflow_error_pulse,
  output logic [1:0]        ov_tim_state
);

  localparam int RAM_D = FLOW_NUM << DEPTH_W;

  tim_state_e state_q, state_d;
  logic [FLOW_W-1:0] flow_q, flow_d;
  logic [DESC_W-1:0] desc_q, desc_d;
  logic ack_q, ack_d;
  logic owr_q, owr_d;
  logic und_q, und_d;
  logic ovf_q, ovf_d;
  logic stale_q, stale_d;
  logic [FLOW_NUM-1:0] cnt_q, cnt_d;

  logic [FLOW_NUM-1:0] enq_v, deq_v, we_v, ovf_v, ovw_v, ne_v;
  logic [DEPTH_W-1:0]  rd_ptr [FLOW_NUM];
  logic [DEPTH_W-1:0]  wr_ptr [FLOW_NUM];
  logic [DEPTH_W:0]    count  [FLOW_NUM];
  logic                deq_en;
  logic                cur_empty;

  logic [DESC_W-1:0] mem_q [RAM_D];
  logic [FLOW_W+DEPTH_W-1:0] waddr, raddr;

  for (genvar f = 0; f < FLOW_NUM; f++) begin : g_flow
    assign enq_v[f] = i_ts_descriptor_wr &&
                      (iv_ts_descriptor_waddr == FLOW_W'(f));
    assign deq_v[f] = deq_en && (flow_q == FLOW_W'(f));

    ts_flow_queue_ctrl #(
      .DEPTH   (DEPTH),
      .DEPTH_W (DEPTH_W)
    ) u_q (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .enq        (enq_v[f]),
      .deq        (deq_v[f]),
      .ovw_mode   (i_overwrite_mode),
      .we         (we_v[f]),
      .ovf        (ovf_v[f]),
      .ovw        (ovw_v[f]),
      .rd_ptr     (rd_ptr[f]),
      .wr_ptr     (wr_ptr[f]),
      .count      (count[f]),
      .nonempty_d (ne_v[f])
    );
  end

  assign waddr = {iv_ts_descriptor_waddr, wr_ptr[iv_ts_descriptor_waddr]};
  assign raddr = {flow_q, rd_ptr[flow_q]};

  always_ff @(posedge i_clk) begin
    if (|we_v) mem_q[waddr] <= iv_ts_descriptor;
  end

  assign cur_empty = (count[flow_q] == '0);
  // A stale entry was already overwritten away; popping it again would lose data.
  assign deq_en = (state_q == ST_OUTPUT) && i_ts_descriptor_ack && !stale_q;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == ST_IDLE:
        if (i_ts_injection_addr_wr) state_d = ST_LOOKUP;
      state_q == ST_LOOKUP:
        state_d = cur_empty ? ST_IDLE : ST_OUTPUT;
      state_q == ST_OUTPUT:
        if (i_ts_descriptor_ack) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flow_d  = flow_q;
    desc_d  = desc_q;
    ack_d   = 1'b0;
    owr_d   = 1'b0;
    und_d   = 1'b0;
    stale_d = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (i_ts_injection_addr_wr) begin
          ack_d  = 1'b1;
          flow_d = iv_ts_injection_addr;
        end
      end
      state_q == ST_LOOKUP: begin
        stale_d = ovw_v[flow_q];
        if (cur_empty) begin
          und_d = 1'b1;
        end else begin
          desc_d = mem_q[raddr];
          owr_d  = 1'b1;
        end
      end
      state_q == ST_OUTPUT: begin
        owr_d   = !i_ts_descriptor_ack;
        stale_d = stale_q | ovw_v[flow_q];
      end
      default: ;
    endcase
  end

  assign ovf_d = |ovf_v;
  assign cnt_d = ne_v;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      flow_q  <= '0;
      desc_q  <= '0;
      ack_q   <= 1'b0;
      owr_q   <= 1'b0;
      und_q   <= 1'b0;
      ovf_q   <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flow_q  <= flow_d;
      desc_q  <= desc_d;
      ack_q   <= ack_d;
      owr_q   <= owr_d;
      und_q   <= und_d;
      ovf_q   <= ovf_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ts_injection_addr_ack    = ack_q;
  assign ov_ts_descriptor           = desc_q;
  assign o_ts_descriptor_wr         = owr_q;
  assign ov_ts_cnt                  = cnt_q;
  assign o_ts_overflow_error_pulse  = ovf_q;
  assign o_ts_underflow_error_pulse = und_q;
  assign ov_tim_state               = state_q;

endmodule
